fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetcher sitting directly upstream of the decoder and reservation station. It holds the PC, looks instructions up in a small direct-mapped instruction cache, and fills misses through the memory controller. It presents one instruction per issue to the decoder and drives the reservation station's fetcher-enable strobe. It stalls on reservation-station or ROB back-pressure and redirects the PC on a ROB flush.

## Interface
- ICACHE_LINES, 16: direct-mapped lines of one 32-bit word each; power of two.
- RESET_PC, 32'h0: PC loaded on reset.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global ready; when low, all state holds.
- in_rs_isidle  in  1  reservation station has a free entry.
- in_rob_isidle  in  1  ROB has a free entry.
- in_rob_flush  in  1  mispredict/redirect strobe.
- in_rob_target_pc  in  32  new PC, valid with in_rob_flush.
- out_mem_ce  out  1  instruction-fetch request to the memory controller.
- out_mem_addr  out  32  word-aligned fetch address.
- in_mem_data  in  32  returned instruction word.
- in_mem_done  in  1  one-cycle pulse; in_mem_data is valid in that cycle.
- out_decode_ce  out  1  instruction valid; feeds the decoder and the reservation station's in_fetcher_ce.
- out_decode_inst  out  32  instruction word.
- out_decode_pc  out  32  PC of that instruction.

## Operation
- Cache addressing:
  - index = pc[log2(ICACHE_LINES)+1:2]
  - tag = pc[31:log2(ICACHE_LINES)+2]
  - hit = valid[index] && tag matches.
- FSM has three states: IDLE, WAIT_MEM, FLUSH_WAIT.
- IDLE, issue: on hit, with in_rs_isidle && in_rob_isidle && !out_decode_ce:
  - register inst and pc onto the decode outputs;
  - out_decode_ce <= 1;
  - pc <= pc+4.
- Issue rate is capped at one per two cycles because in_rs_isidle lags the registered strobe by one cycle. The last free RS slot must never be claimed twice.
- IDLE, miss: out_mem_ce <= 1, out_mem_addr <= pc, go to WAIT_MEM.
- WAIT_MEM: out_mem_ce and out_mem_addr are held. On in_mem_done:
  - write the line: data, tag, valid <= 1;
  - out_mem_ce <= 0;
  - go to IDLE. The next cycle hits.
- Flush, highest priority, any state:
  - pc <= in_rob_target_pc;
  - out_decode_ce <= 0 that cycle.
  - In WAIT_MEM without in_mem_done in the same cycle: go to FLUSH_WAIT.
- FLUSH_WAIT: the request stays asserted until in_mem_done, because the controller cannot abort. The fill is written to the cache, then the FSM goes to IDLE at the redirected PC.
- Flush and in_mem_done in the same cycle: perform the fill, apply the redirect, go to IDLE.
- out_decode_ce is a one-cycle pulse per issue. It is cleared in every rdy cycle that does not issue.
- rdy low: every register holds, including out_decode_ce and out_mem_ce.

## Timing
- Reset values:
  - pc = RESET_PC, all valid bits = 0, state IDLE;
  - out_mem_ce = 0, out_mem_addr = 0;
  - out_decode_ce = 0, out_decode_inst = 0, out_decode_pc = 0.
- Hit: decision at edge k, so out_decode_ce is high during cycle k+1.
- Miss: request visible the cycle after the miss is detected. With memory latency L from request to done:
  - fill written at the done edge;
  - issue decided the following cycle;
  - out_decode_ce L+2 cycles after the request edge.
- Sustained hit throughput is 1 instruction per 2 cycles.
- Flush at edge k: first fetch of target_pc is decided at edge k+1 (cache hit) or its miss request is raised at edge k+1.
- PC wraps modulo 2^32 with no exception.

## Structure
- Shared header constants:
  - DATA_WIDTH, ADDR_WIDTH;
  - ICACHE index/tag widths;
  - FSM state encodings;
  - TRUE/FALSE.
- Sub-module fetch_icache: tag/data/valid arrays, combinational hit/data read, one write port. Reset clears valid only.
- The FSM, PC and output registers live in fetch_unit.

## Test plan
- Reset then cold start: rst for 2 cycles, memory returns 32'h00000013 after L=3 → out_mem_addr=0, out_decode_ce pulses with inst=32'h13, pc=0. The next request uses addr 4.
- Warm loop: pc 0..12 preloaded in cache, both idles high → out_decode_ce on alternate cycles, pcs 0,4,8,12; no out_mem_ce.
- Back-pressure: in_rs_isidle low for 5 cycles with a cache hit → no out_decode_ce and pc unchanged. Issue occurs the cycle after idle returns.
- Flush during WAIT_MEM: flush to 32'h100 two cycles into a miss at 32'h40 → request held until done, line 0x40 filled, nothing issued from 0x40. Next request addr=32'h100.
- Simultaneous flush and in_mem_done → fill written, state IDLE, pc=target, no stray out_decode_ce.
- rdy low mid-miss for 4 cycles while done is not pulsed → all outputs frozen. Behaviour resumes identically when rdy returns.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared widths, cache geometry and FSM encodings for the fetch unit
package fetch_unit_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int ADDR_WIDTH        = 32;
    localparam int ICACHE_LINES_DEF  = 16;
    localparam int ICACHE_INDEX_W    = $clog2(ICACHE_LINES_DEF);
    localparam int ICACHE_TAG_W      = ADDR_WIDTH - ICACHE_INDEX_W - 2;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_MEM   = 2'd1,
        ST_FLUSH_WAIT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - memory-controller fetch port and decoder issue port of the fetch unit
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic                  out_mem_ce;
    logic [ADDR_WIDTH-1:0] out_mem_addr;
    logic [DATA_WIDTH-1:0] in_mem_data;
    logic                  in_mem_done;
    logic                  out_decode_ce;
    logic [DATA_WIDTH-1:0] out_decode_inst;
    logic [ADDR_WIDTH-1:0] out_decode_pc;

    modport master (
        output out_mem_ce, out_mem_addr, out_decode_ce, out_decode_inst, out_decode_pc,
        input  in_mem_data, in_mem_done
    );

    modport slave (
        input  out_mem_ce, out_mem_addr, out_decode_ce, out_decode_inst, out_decode_pc,
        output in_mem_data, in_mem_done
    );

endinterface

// File: rtl/fetch_icache.sv
// rtl/fetch_icache.sv - direct-mapped one-word-per-line instruction cache, async read, one write port
module fetch_icache
    import fetch_unit_pkg::*;
#(
    parameter int LINES   = ICACHE_LINES_DEF,
    parameter int INDEX_W = $clog2(LINES),
    parameter int TAG_W   = ADDR_WIDTH - 2 - INDEX_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-3:0]   rd_word,
    output logic                    hit,
    output logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-3:0]   wr_word,
    input  logic [DATA_WIDTH-1:0]   wr_data
);

    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES];
    logic [LINES-1:0]      valid_q;

    logic [INDEX_W-1:0] rd_index, wr_index;
    logic [TAG_W-1:0]   rd_tag, wr_tag;

    assign rd_index = rd_word[INDEX_W-1:0];
    assign rd_tag   = rd_word[ADDR_WIDTH-3:INDEX_W];
    assign wr_index = wr_word[INDEX_W-1:0];
    assign wr_tag   = wr_word[ADDR_WIDTH-3:INDEX_W];

    assign hit     = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
    assign rd_data = data_q[rd_index];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= TRUE;
        end
    end

    // Tag and data arrays need no reset: a line is only read once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, icache lookup, miss fill and one-per-two-cycle issue to the decoder
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                    ICACHE_LINES = ICACHE_LINES_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  in_rs_isidle,
    input  logic                  in_rob_isidle,
    input  logic                  in_rob_flush,
    input  logic [ADDR_WIDTH-1:0] in_rob_target_pc,
    fetch_unit_if.master          bus
);

    localparam int INDEX_W = $clog2(ICACHE_LINES);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  hit;
    logic [DATA_WIDTH-1:0] cache_inst;
    logic                  do_issue, do_req, do_fill, cache_we;

    // Fill address comes from the held request, not the PC, so a redirected PC cannot misplace the line.
    fetch_icache #(.LINES(ICACHE_LINES), .INDEX_W(INDEX_W)) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_word (pc_q[ADDR_WIDTH-1:2]),
        .hit     (hit),
        .rd_data (cache_inst),
        .wr_en   (cache_we),
        .wr_word (bus.out_mem_addr[ADDR_WIDTH-1:2]),
        .wr_data (bus.in_mem_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (do_req) state_d = ST_WAIT_MEM;
            ST_WAIT_MEM: begin
                if (bus.in_mem_done)   state_d = ST_IDLE;
                else if (in_rob_flush) state_d = ST_FLUSH_WAIT;
            end
            ST_FLUSH_WAIT: if (bus.in_mem_done) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // Gating on out_decode_ce holds issue to every other cycle: in_rs_isidle lags the strobe by one cycle.
    always_comb begin
        do_fill  = (state_q != ST_IDLE) && bus.in_mem_done;
        do_issue = !in_rob_flush && (state_q == ST_IDLE) && hit
                   && in_rs_isidle && in_rob_isidle && !bus.out_decode_ce;
        do_req   = !in_rob_flush && (state_q == ST_IDLE) && !hit;
        cache_we = rdy && do_fill;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q                <= RESET_PC;
            bus.out_mem_ce      <= FALSE;
            bus.out_mem_addr    <= '0;
            bus.out_decode_ce   <= FALSE;
            bus.out_decode_inst <= '0;
            bus.out_decode_pc   <= '0;
        end else if (rdy) begin
            bus.out_decode_ce <= do_issue;
            if (do_issue) begin
                bus.out_decode_inst <= cache_inst;
                bus.out_decode_pc   <= pc_q;
            end
            if (in_rob_flush) begin
                pc_q <= in_rob_target_pc;
            end else if (do_issue) begin
                pc_q <= pc_q + 32'd4;
            end
            if (do_req) begin
                bus.out_mem_ce   <= TRUE;
                bus.out_mem_addr <= {pc_q[ADDR_WIDTH-1:2], 2'b00};
            end else if (do_fill) begin
                bus.out_mem_ce   <= FALSE;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        in_rs_isidle = 1'b1;
    logic        in_rob_isidle = 1'b1;
    logic        in_rob_flush = 1'b0;
    logic [31:0] in_rob_target_pc = 32'h0;

    int checks = 0;
    int errors = 0;

    fetch_unit_if bus ();

    fetch_unit #(.ICACHE_LINES(16), .RESET_PC(32'h0)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .in_rs_isidle     (in_rs_isidle),
        .in_rob_isidle    (in_rob_isidle),
        .in_rob_flush     (in_rob_flush),
        .in_rob_target_pc (in_rob_target_pc),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] D20  = 32'h01400293;
    localparam logic [31:0] D40  = 32'h04000313;
    localparam logic [31:0] D100 = 32'h10000393;
    localparam logic [31:0] DW   = 32'hfff00413;

    logic [31:0] imem [0:4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mem_reply(input logic [31:0] d, input int lat);
        for (int i = 1; i < lat; i++) step();
        bus.in_mem_data = d;
        bus.in_mem_done = 1'b1;
        step();
        bus.in_mem_done = 1'b0;
    endtask

    initial begin
        imem[0] = 32'h00000013;
        imem[1] = 32'h00400093;
        imem[2] = 32'h00800113;
        imem[3] = 32'h00c00193;
        imem[4] = 32'h01000213;
        bus.in_mem_data = 32'h0;
        bus.in_mem_done = 1'b0;

        // reset and cold start
        step(); step();
        check("rst_mem_ce", {31'd0, bus.out_mem_ce}, 32'd0);
        check("rst_mem_addr", bus.out_mem_addr, 32'h0);
        check("rst_dec_ce", {31'd0, bus.out_decode_ce}, 32'd0);
        check("rst_dec_inst", bus.out_decode_inst, 32'h0);
        check("rst_dec_pc", bus.out_decode_pc, 32'h0);
        rst = 1'b0;
        step();
        check("cold_req_ce", {31'd0, bus.out_mem_ce}, 32'd1);
        check("cold_req_addr", bus.out_mem_addr, 32'h0);
        mem_reply(imem[0], 3);
        check("cold_fill_ce_low", {31'd0, bus.out_mem_ce}, 32'd0);
        check("cold_no_early_issue", {31'd0, bus.out_decode_ce}, 32'd0);
        step();
        check("cold_issue_ce", {31'd0, bus.out_decode_ce}, 32'd1);
        check("cold_issue_inst", bus.out_decode_inst, 32'h00000013);
        check("cold_issue_pc", bus.out_decode_pc, 32'h0);

        // fill lines 4, 8, 12 through misses
        for (int i = 1; i <= 3; i++) begin
            step();
            check("fill_req_ce", {31'd0, bus.out_mem_ce}, 32'd1);
            check("fill_req_addr", bus.out_mem_addr, 32'(4 * i));
            check("fill_req_dec_low", {31'd0, bus.out_decode_ce}, 32'd0);
            mem_reply(imem[i], 1);
            step();
            check("fill_issue_pc", bus.out_decode_pc, 32'(4 * i));
            check("fill_issue_inst", bus.out_decode_inst, imem[i]);
        end
        step();
        check("req16_addr", bus.out_mem_addr, 32'h10);

        // flush back to 0 while waiting on line 16; the fill still lands
        in_rob_flush = 1'b1;
        in_rob_target_pc = 32'h0;
        step();
        in_rob_flush = 1'b0;
        check("fw_hold_ce", {31'd0, bus.out_mem_ce}, 32'd1);
        check("fw_hold_addr", bus.out_mem_addr, 32'h10);
        mem_reply(imem[4], 1);
        check("fw_done_ce", {31'd0, bus.out_mem_ce}, 32'd0);
        check("fw_no_issue", {31'd0, bus.out_decode_ce}, 32'd0);

        // warm loop: alternate-cycle issue of 0,4,8,12 with no memory traffic
        for (int i = 0; i < 8; i++) begin
            step();
            check("warm_ce", {31'd0, bus.out_decode_ce}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("warm_mem_ce", {31'd0, bus.out_mem_ce}, 32'd0);
            if (i % 2 == 0) begin
                check("warm_pc", bus.out_decode_pc, 32'(2 * i));
                check("warm_inst", bus.out_decode_inst, imem[i / 2]);
            end
        end

        // back-pressure on a hit at pc 16
        in_rs_isidle = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_no_issue", {31'd0, bus.out_decode_ce}, 32'd0);
            check("bp_no_req", {31'd0, bus.out_mem_ce}, 32'd0);
        end
        in_rs_isidle = 1'b1;
        step();
        check("bp_issue_ce", {31'd0, bus.out_decode_ce}, 32'd1);
        check("bp_issue_pc", bus.out_decode_pc, 32'h10);
        check("bp_issue_inst", bus.out_decode_inst, imem[4]);
        step();
        check("req20_ce", {31'd0, bus.out_mem_ce}, 32'd1);
        check("req20_addr", bus.out_mem_addr, 32'h14);

        // flush and done in the same cycle
        in_rob_flush = 1'b1;
        in_rob_target_pc = 32'h40;
        bus.in_mem_data = D20;
        bus.in_mem_done = 1'b1;
        step();
        in_rob_flush = 1'b0;
        bus.in_mem_done = 1'b0;
        check("simul_ce_low", {31'd0, bus.out_mem_ce}, 32'd0);
        check("simul_no_issue", {31'd0, bus.out_decode_ce}, 32'd0);
        step();
        check("req40_ce", {31'd0, bus.out_mem_ce}, 32'd1);
        check("req40_addr", bus.out_mem_addr, 32'h40);

        // flush to 0x100 two cycles into the 0x40 miss
        step();
        in_rob_flush = 1'b1;
        in_rob_target_pc = 32'h100;
        step();
        in_rob_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("fw40_ce", {31'd0, bus.out_mem_ce}, 32'd1);
            check("fw40_addr", bus.out_mem_addr, 32'h40);
            check("fw40_no_issue", {31'd0, bus.out_decode_ce}, 32'd0);
            if (i < 2) step();
        end
        mem_reply(D40, 1);
        check("fw40_done_ce", {31'd0, bus.out_mem_ce}, 32'd0);
        check("fw40_done_dec", {31'd0, bus.out_decode_ce}, 32'd0);
        step();
        check("req100_ce", {31'd0, bus.out_mem_ce}, 32'd1);
        check("req100_addr", bus.out_mem_addr, 32'h100);
        check("req100_no_issue", {31'd0, bus.out_decode_ce}, 32'd0);

        // rdy low mid-miss
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rdy_mem_ce", {31'd0, bus.out_mem_ce}, 32'd1);
            check("rdy_mem_addr", bus.out_mem_addr, 32'h100);
            check("rdy_dec_ce", {31'd0, bus.out_decode_ce}, 32'd0);
        end
        rdy = 1'b1;
        mem_reply(D100, 2);
        check("f100_ce_low", {31'd0, bus.out_mem_ce}, 32'd0);
        step();
        check("i100_ce", {31'd0, bus.out_decode_ce}, 32'd1);
        check("i100_pc", bus.out_decode_pc, 32'h100);
        check("i100_inst", bus.out_decode_inst, D100);

        // line 20 was filled by the simultaneous flush/done
        in_rob_flush = 1'b1;
        in_rob_target_pc = 32'h14;
        step();
        in_rob_flush = 1'b0;
        check("flush_dec_low", {31'd0, bus.out_decode_ce}, 32'd0);
        step();
        check("i20_ce", {31'd0, bus.out_decode_ce}, 32'd1);
        check("i20_pc", bus.out_decode_pc, 32'h14);
        check("i20_inst", bus.out_decode_inst, D20);
        check("i20_no_req", {31'd0, bus.out_mem_ce}, 32'd0);

        // rdy low freezes the issue strobe
        rdy = 1'b0;
        step(); step();
        check("rdy_hold_dec_ce", {31'd0, bus.out_decode_ce}, 32'd1);
        check("rdy_hold_dec_pc", bus.out_decode_pc, 32'h14);
        rdy = 1'b1;
        in_rob_flush = 1'b1;
        in_rob_target_pc = 32'h40;
        step();
        in_rob_flush = 1'b0;
        check("rdy_back_dec_low", {31'd0, bus.out_decode_ce}, 32'd0);
        check("rdy_back_no_req", {31'd0, bus.out_mem_ce}, 32'd0);

        // 0x40 shares line 0 with 0x100, so it misses on tag
        step();
        check("tag_miss_ce", {31'd0, bus.out_mem_ce}, 32'd1);
        check("tag_miss_addr", bus.out_mem_addr, 32'h40);

        // PC wrap at the top of the address space
        in_rob_flush = 1'b1;
        in_rob_target_pc = 32'hfffffffc;
        bus.in_mem_data = D40;
        bus.in_mem_done = 1'b1;
        step();
        in_rob_flush = 1'b0;
        bus.in_mem_done = 1'b0;
        step();
        check("reqtop_addr", bus.out_mem_addr, 32'hfffffffc);
        mem_reply(DW, 1);
        step();
        check("itop_pc", bus.out_decode_pc, 32'hfffffffc);
        check("itop_inst", bus.out_decode_inst, DW);
        step();
        check("wrap_req_ce", {31'd0, bus.out_mem_ce}, 32'd1);
        check("wrap_req_addr", bus.out_mem_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
